uart_beep_seq: RTL and testbench

- Multi-channel audible event indicator; successor of the single-input UART beep.
- Each of NUM_CH event inputs (UART rx-done, tx-done, FIR result-ready, error, ...) is edge-detected and queued.
- Events are served one at a time. Channel i sounds as i+1 beep bursts, so the listener can tell which source fired.
- Sits between the UART/FIR datapath strobes and the board buzzer pin.

---
 rtl/uart_beep_pkg.sv | 31 +++
 rtl/uart_edge_det.sv | 29 ++
 rtl/uart_beep_seq.sv | 191 +++++++++++++++++++
 tb/tb_uart_beep_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_beep_pkg.sv
// Shared definitions for the multi-channel beep sequencer:
// FSM state encodings, a ceil-log2 helper and default timing constants.
package uart_beep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_GAP  = 2'd2,
      ST_HOLD = 2'd3
   } beep_state_e;

   localparam int unsigned DEF_NUM_CH         = 4;
   localparam int unsigned DEF_CNT_W          = 27;
   localparam int unsigned DEF_ON_CYCLES      = 5000000;
   localparam int unsigned DEF_OFF_CYCLES     = 2500000;
   localparam int unsigned DEF_HOLDOFF_CYCLES = 10000000;
   localparam int unsigned DEF_TONE_DIV       = 12500;

   // Smallest r with 2**r >= value (0 for value <= 1).
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      if (value > 1) begin
         for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_edge_det.sv
// One event channel: 3-flop synchroniser for an asynchronous level and a
// single-cycle rise strobe taken from the two settled stages.
module uart_edge_det (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic evt_in,
   output logic rise
);

   logic s0;
   logic s1;
   logic s2;

   // Synchroniser chain, cleared by reset.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         s0 <= 1'b0;
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s0 <= evt_in;
         s1 <= s0;
         s2 <= s1;
      end
   end

   assign rise = s1 & ~s2;

endmodule

// File: rtl/uart_beep_seq.sv
// Multi-channel audible event indicator. Each channel's rising edge queues a
// one-deep request; requests are served lowest index first and channel i
// sounds as i+1 bursts, followed by an optional holdoff.
// Optional feature: define UART_BEEP_TONE_EN to drive beep_out with a square
// wave (passive buzzer) instead of the plain burst gate.
module uart_beep_seq
   import uart_beep_pkg::*;
#(
   parameter int unsigned NUM_CH         = DEF_NUM_CH,
   parameter int unsigned CNT_W          = DEF_CNT_W,
   parameter int unsigned ON_CYCLES      = DEF_ON_CYCLES,
   parameter int unsigned OFF_CYCLES     = DEF_OFF_CYCLES,
   parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
   parameter int unsigned TONE_DIV       = DEF_TONE_DIV
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [NUM_CH-1:0] evt_in,
   output logic              beep_en,
   output logic              beep_out,
   output logic              busy,
   output logic [2:0]        active_ch,
   output logic [NUM_CH-1:0] pend
);

   localparam int unsigned BW = clog2(NUM_CH + 1);
   localparam longint unsigned CNT_LIM = 64'd1 << CNT_W;
   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST =
      CNT_W'((HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1);

   if (NUM_CH < 1 || NUM_CH > 8) begin : g_chk_ch
      $error("uart_beep_seq: NUM_CH must be 1..8");
   end
   if (ON_CYCLES < 1 || OFF_CYCLES < 1 || TONE_DIV < 1) begin : g_chk_min
      $error("uart_beep_seq: ON_CYCLES, OFF_CYCLES and TONE_DIV must be >= 1");
   end
   if (64'(ON_CYCLES) >= CNT_LIM || 64'(OFF_CYCLES) >= CNT_LIM ||
       64'(HOLDOFF_CYCLES) >= CNT_LIM || 64'(TONE_DIV) >= CNT_LIM) begin : g_chk_w
      $error("uart_beep_seq: timing parameters must fit in CNT_W bits");
   end

   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] pend_n;
   logic [NUM_CH-1:0] grant_mask;
   logic [2:0]        grant_idx;
   logic              any_pend;
   logic              grant;

   beep_state_e       state;
   beep_state_e       state_n;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_n;
   logic [BW-1:0]     beeps_left;
   logic [BW-1:0]     beeps_n;
   logic [2:0]        ach_n;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_det
      uart_edge_det u_det (
         .sys_clk (sys_clk),
         .sys_rst (sys_rst),
         .evt_in  (evt_in[g]),
         .rise    (rise[g])
      );
   end

   // Fixed-priority pick of the lowest pending channel.
   always_comb begin
      grant_mask = '0;
      grant_idx  = '0;
      any_pend   = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (pend[i] && !any_pend) begin
            any_pend      = 1'b1;
            grant_mask[i] = 1'b1;
            grant_idx     = 3'(i);
         end
      end
   end

   // Next-state, counter, burst count and request-queue logic.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      beeps_n = beeps_left;
      ach_n   = active_ch;
      grant   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (any_pend) begin
               grant   = 1'b1;
               ach_n   = grant_idx;
               beeps_n = BW'(grant_idx) + BW'(1);
               cnt_n   = '0;
               state_n = ST_ON;
            end
         end
         ST_ON: begin
            if (cnt == ON_LAST) begin
               cnt_n = '0;
               if (beeps_left > BW'(1)) begin
                  beeps_n = beeps_left - BW'(1);
                  state_n = ST_GAP;
               end else if (HOLDOFF_CYCLES == 0) begin
                  ach_n   = '0;
                  state_n = ST_IDLE;
               end else begin
                  state_n = ST_HOLD;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (cnt == OFF_LAST) begin
               cnt_n   = '0;
               state_n = ST_ON;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (cnt == HOLD_LAST) begin
               cnt_n   = '0;
               ach_n   = '0;
               state_n = ST_IDLE;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
      // A rise on the same edge as the grant wins, so that channel replays.
      pend_n = (grant ? (pend & ~grant_mask) : pend) | rise;
   end

   // FSM state register.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Datapath registers; beep_en/busy are decoded from the next state so they
   // line up with the state register rather than lagging it by a cycle.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt        <= '0;
         beeps_left <= '0;
         active_ch  <= '0;
         pend       <= '0;
         beep_en    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         cnt        <= cnt_n;
         beeps_left <= beeps_n;
         active_ch  <= ach_n;
         pend       <= pend_n;
         beep_en    <= (state_n == ST_ON);
         busy       <= (state_n != ST_IDLE);
      end
   end

`ifdef UART_BEEP_TONE_EN
   localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_DIV - 1);

   logic [CNT_W-1:0] tone_cnt;
   logic             tone_q;

   // Tone divider: restarts at 0 on each burst entry, held at 0 outside ON.
   always_ff @(posedge sys_clk) begin
      if (sys_rst || state_n != ST_ON || state != ST_ON) begin
         tone_cnt <= '0;
         tone_q   <= 1'b0;
      end else if (tone_cnt == TONE_LAST) begin
         tone_cnt <= '0;
         tone_q   <= ~tone_q;
      end else begin
         tone_cnt <= tone_cnt + CNT_W'(1);
      end
   end

   assign beep_out = tone_q;
`else
   assign beep_out = beep_en;
`endif

endmodule

// File: tb/tb_uart_beep_seq.sv
// Self-checking bench for uart_beep_seq (NUM_CH=4, ON=4, OFF=2, HOLDOFF=3).
// Every cycle is compared against a schedule-based reference model; a vector
// table and directed sequences cover the named corner cases, then random
// event traffic with occasional resets.
module tb_uart_beep_seq;

   localparam int NCH  = 4;
   localparam int ON   = 4;
   localparam int OFF  = 2;
   localparam int HOLD = 3;
   localparam int TDIV = 1;
   localparam int CW   = 8;
`ifdef UART_BEEP_TONE_EN
   localparam bit TONE = 1'b1;
`else
   localparam bit TONE = 1'b0;
`endif

   logic           sys_clk = 1'b0;
   logic           sys_rst = 1'b1;
   logic [NCH-1:0] evt_in  = '0;
   logic           beep_en;
   logic           beep_out;
   logic           busy;
   logic [2:0]     active_ch;
   logic [NCH-1:0] pend;

   uart_beep_seq #(
      .NUM_CH         (NCH),
      .CNT_W          (CW),
      .ON_CYCLES      (ON),
      .OFF_CYCLES     (OFF),
      .HOLDOFF_CYCLES (HOLD),
      .TONE_DIV       (TDIV)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .evt_in    (evt_in),
      .beep_en   (beep_en),
      .beep_out  (beep_out),
      .busy      (busy),
      .active_ch (active_ch),
      .pend      (pend)
   );

   always #5 sys_clk = ~sys_clk;

   int n_pass  = 0;
   int n_total = 0;
   int n_beep  = 0;
   int n_busy  = 0;
   int n_bad_ch = 0;

   // Reference model: last three input samples, request flags, current job.
   logic [NCH-1:0] m_samp [3];
   logic [NCH-1:0] m_pend = '0;
   bit             m_busy = 1'b0;
   int             m_ch   = 0;
   int             m_t    = 0;

   function automatic int job_len(input int c);
      return (c + 1) * ON + c * OFF + HOLD;
   endfunction

   function automatic bit beep_at(input int c, input int t);
      return (t < (c + 1) * ON + c * OFF) && ((t % (ON + OFF)) < ON);
   endfunction

   function automatic bit out_at(input int c, input int t);
      if (!beep_at(c, t)) return 1'b0;
      if (!TONE) return 1'b1;
      return bit'(((t % (ON + OFF)) / TDIV) % 2);
   endfunction

   task automatic model_edge(input logic [NCH-1:0] e, input logic r);
      logic [NCH-1:0] rise;
      if (r) begin
         for (int k = 0; k < 3; k++) m_samp[k] = '0;
         m_pend = '0;
         m_busy = 1'b0;
         m_t    = 0;
         m_ch   = 0;
      end else begin
         rise = m_samp[1] & ~m_samp[2];
         m_samp[2] = m_samp[1];
         m_samp[1] = m_samp[0];
         m_samp[0] = e;
         if (m_busy) begin
            m_t = m_t + 1;
            if (m_t == job_len(m_ch)) m_busy = 1'b0;
         end else if (m_pend != '0) begin
            for (int c = NCH - 1; c >= 0; c--) if (m_pend[c]) m_ch = c;
            m_pend[m_ch] = 1'b0;
            m_busy = 1'b1;
            m_t    = 0;
         end
         m_pend = m_pend | rise;
      end
   endtask

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got {en,out,busy,ch,pend}=%b required %b at %0t", name, act, exp, $time);
   endtask

   function automatic logic [9:0] dut_vec();
      return {beep_en, beep_out, busy, active_ch, pend};
   endfunction

   // One clock: drive, let the edge happen, advance the model, compare.
   task automatic tick(input logic [NCH-1:0] e, input logic r);
      logic [9:0] exp;
      evt_in  = e;
      sys_rst = r;
      @(posedge sys_clk);
      model_edge(e, r);
      #1;
      exp = {m_busy && beep_at(m_ch, m_t), m_busy && out_at(m_ch, m_t), m_busy,
             m_busy ? 3'(m_ch) : 3'd0, m_pend};
      check("model", dut_vec(), exp);
      n_beep += int'(beep_en);
      n_busy += int'(busy);
      if (busy && active_ch != 3'(m_ch)) n_bad_ch++;
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d required %0d", name, act, exp);
   endtask

   typedef struct {
      logic           rst;
      logic [NCH-1:0] evt;
      logic           en;
      logic           out;
      logic           bsy;
      logic [2:0]     ch;
      logic [NCH-1:0] pd;
   } vec_t;

   vec_t tbl [13];

   initial begin
      logic [NCH-1:0] rnd_evt;
      bit             seen;

      for (int k = 0; k < 3; k++) m_samp[k] = '0;

      // Single 1-cycle pulse on ch0: pend after 3 edges, grant on the 4th,
      // 4 cycles of beep then 3 of hold.
      tbl[0] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000};
      tbl[1] = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000};
      tbl[2] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000};
      tbl[3] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0001};
      for (int i = 4; i < 8; i++)
         tbl[i] = '{1'b0, 4'b0000, 1'b1, TONE ? logic'((i - 4) % 2) : 1'b1, 1'b1, 3'd0, 4'b0000};
      for (int i = 8; i < 11; i++)
         tbl[i] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 3'd0, 4'b0000};
      tbl[11] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000};
      tbl[12] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000};

      for (int i = 0; i < 13; i++) begin
         tick(tbl[i].evt, tbl[i].rst);
         check($sformatf("tbl%0d", i), dut_vec(),
               {tbl[i].en, tbl[i].out, tbl[i].bsy, tbl[i].ch, tbl[i].pd});
      end

      // Ch2: three bursts with gaps, then hold, active_ch=2 throughout.
      n_beep = 0; n_busy = 0; n_bad_ch = 0;
      tick(4'b0100, 1'b0);
      for (int i = 0; i < 40; i++) tick('0, 1'b0);
      check_int("ch2_beep_cycles", n_beep, 12);
      check_int("ch2_busy_cycles", n_busy, 19);
      check_int("ch2_active_ch_errs", n_bad_ch, 0);

      // Ch1 and ch3 together: ch1 first, ch3 afterwards.
      n_beep = 0;
      tick(4'b1010, 1'b0);
      tick('0, 1'b0);
      tick('0, 1'b0);
      check_int("dual_pend_before", int'(pend), 10);
      tick('0, 1'b0);
      check_int("dual_pend_after", int'(pend), 8);
      check_int("dual_first_ch", int'(active_ch), 1);
      for (int i = 0; i < 60; i++) tick('0, 1'b0);
      check_int("dual_beep_cycles", n_beep, 24);

      // Ch0 held high: one request only.
      n_beep = 0;
      for (int i = 0; i < 100; i++) tick(4'b0001, 1'b0);
      for (int i = 0; i < 20; i++) tick('0, 1'b0);
      check_int("held_beep_cycles", n_beep, 4);

      // Three re-triggers while ch0 sounds merge into exactly one replay.
      n_beep = 0;
      seen = 1'b0;
      tick(4'b0001, 1'b0);
      for (int i = 0; i < 10 && !seen; i++) begin
         tick('0, 1'b0);
         seen = beep_en;
      end
      check_int("retrig_burst_started", int'(seen), 1);
      for (int i = 0; i < 3; i++) begin
         tick(4'b0001, 1'b0);
         tick('0, 1'b0);
      end
      for (int i = 0; i < 40; i++) tick('0, 1'b0);
      check_int("retrig_beep_cycles", n_beep, 8);

      // Reset in the 2nd ON cycle with ch3 still queued.
      tick(4'b1001, 1'b0);
      tick('0, 1'b0);
      tick('0, 1'b0);
      tick('0, 1'b0);
      tick('0, 1'b0);
      check_int("rst_pre_beep", int'(beep_en), 1);
      check_int("rst_pre_pend", int'(pend), 8);
      tick('0, 1'b1);
      check("rst_mid_burst", dut_vec(), 10'b0);
      n_beep = 0; n_busy = 0;
      for (int i = 0; i < 40; i++) tick('0, 1'b0);
      check_int("rst_no_later_beep", n_beep + n_busy, 0);

      // Random event traffic with sparse resets.
      rnd_evt = '0;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < NCH; b++)
            if ($urandom_range(15) == 0) rnd_evt[b] = ~rnd_evt[b];
         tick(rnd_evt, ($urandom_range(399) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
